// File: rtl/node_pkg.sv
// Shared definitions for computation-tree nodes: operator encodings,
// controller states and the default datapath width.
package node_pkg;

  localparam int DATA_W = 16;

  localparam int OP_ADD   = 0;
  localparam int OP_MONUS = 1;
  localparam int OP_MUL   = 2;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CALC
  } state_t;

endpackage

// File: rtl/node_mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, W-bit product.
// `result` and `done` are combinational and describe the iteration taken at the next edge.
module node_mul_seq #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         abort,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  acc;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [W-1:0]  src_acc;
  logic [W-1:0]  src_mc;
  logic [W-1:0]  src_mp;

  // The start cycle already performs iteration 1 from the raw operands,
  // so the final product is ready W edges after start is first seen.
  always_comb begin
    src_acc = start ? '0 : acc;
    src_mc  = start ? a  : mcand;
    src_mp  = start ? b  : mplier;
    result  = src_acc + (src_mp[0] ? src_mc : '0);
    done    = start ? (W == 1) : (busy && (cnt == CW'(W - 1)));
  end

  // NOTE: only the control bits are reset; acc/mcand/mplier are always
  // reloaded on start before they are read, so they need no reset.
  always_ff @(posedge CLK) begin
    if (RST || abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start || busy) begin
      acc    <= result;
      mcand  <= src_mc << 1;
      mplier <= src_mp >> 1;
      cnt    <= start ? CW'(1) : cnt + CW'(1);
      busy   <= !done;
    end
  end

endmodule

// File: rtl/node_join2_op.sv
// Binary composition node: launches both children, joins their RD/RES
// handshakes, applies the OP-selected operator and reports via RD/RES.
module node_join2_op
  import node_pkg::*;
#(
  parameter int W  = DATA_W,
  parameter int OP = OP_ADD
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ST,
  output logic         RD,
  output logic [W-1:0] RES,
  output logic         CST,
  input  logic         CRD0,
  input  logic         CRD1,
  input  logic [W-1:0] CRES0,
  input  logic [W-1:0] CRES1
);

  state_t       state;
  logic         st_old;
  logic         start_evt;
  logic         seen0, seen1;
  logic         done0, done1;
  logic [W-1:0] op_a, op_b;
  logic [W-1:0] calc_res;
  logic         mul_done;
  logic [W-1:0] mul_res;

  assign start_evt = ST & ~st_old;

  // NOTE: always_comb gives every output a default first, so no latch is inferred.
  always_comb begin
    calc_res = op_a + op_b;
    if (OP == OP_MONUS) calc_res = (op_a > op_b) ? op_a - op_b : '0;
  end

  if (OP == OP_MUL) begin : g_mul
    logic busy;
    node_mul_seq #(.W(W)) u_mul (
      .CLK    (CLK),
      .RST    (RST),
      .abort  (start_evt),
      .start  (state == CALC && !busy),
      .a      (op_a),
      .b      (op_b),
      .busy   (busy),
      .done   (mul_done),
      .result (mul_res)
    );
  end else begin : g_no_mul
    assign mul_done = 1'b0;
    assign mul_res  = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    st_old <= ST;  // tracks ST even in reset, so a held ST never retriggers
    if (RST) begin
      state <= IDLE;
      RD    <= 1'b1;
      RES   <= '0;
      CST   <= 1'b0;
      seen0 <= 1'b0;
      seen1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
    end else if (start_evt) begin
      state <= LAUNCH;
      RD    <= 1'b0;
      CST   <= 1'b1;
      seen0 <= 1'b0;
      seen1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
    end else begin
      case (state)
        LAUNCH: begin
          CST   <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          // A child's ready only counts after it has been seen low this operation.
          if (!seen0) begin
            if (!CRD0) seen0 <= 1'b1;
          end else if (!done0 && CRD0) begin
            op_a  <= CRES0;
            done0 <= 1'b1;
          end
          if (!seen1) begin
            if (!CRD1) seen1 <= 1'b1;
          end else if (!done1 && CRD1) begin
            op_b  <= CRES1;
            done1 <= 1'b1;
          end
          if (done0 && done1) state <= CALC;
        end
        CALC: begin
          if (OP == OP_MUL) begin
            if (mul_done) begin
              RES   <= mul_res;
              RD    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            RES   <= calc_res;
            RD    <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_node_join2_op.sv
// Scoreboard bench: ADD, MONUS and MUL nodes share ST and bench-modelled
// children; a monitor pops expected results whenever a node's RD rises.
module tb_node_join2_op;
  import node_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a, b;
    int           d0, d1, s0, s1;
    logic [W-1:0] e_add, e_monus, e_mul;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST;
  logic         ST;
  logic         crd [2];
  logic [W-1:0] cres [2];
  logic [2:0]   rd;
  logic [2:0]   cst;
  logic [W-1:0] res [3];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_edge = 0;
  exp_t exp_q [3][$];
  vec_t vecs [7];

  node_join2_op #(.W(W), .OP(OP_ADD)) u_add (
    .CLK(CLK), .RST(RST), .ST(ST), .RD(rd[0]), .RES(res[0]), .CST(cst[0]),
    .CRD0(crd[0]), .CRD1(crd[1]), .CRES0(cres[0]), .CRES1(cres[1]));
  node_join2_op #(.W(W), .OP(OP_MONUS)) u_monus (
    .CLK(CLK), .RST(RST), .ST(ST), .RD(rd[1]), .RES(res[1]), .CST(cst[1]),
    .CRD0(crd[0]), .CRD1(crd[1]), .CRES0(cres[0]), .CRES1(cres[1]));
  node_join2_op #(.W(W), .OP(OP_MUL)) u_mul (
    .CLK(CLK), .RST(RST), .ST(ST), .RD(rd[2]), .RES(res[2]), .CST(cst[2]),
    .CRD0(crd[0]), .CRD1(crd[1]), .CRES0(cres[0]), .CRES1(cres[1]));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every RD rising edge must match the oldest expected result and latency.
  logic [2:0] rd_prev = 3'b111;
  always @(negedge CLK) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (!RST && rd[k] && !rd_prev[k]) begin
        if (exp_q[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd[%0d]: RD rose with RES=%h, none expected", k, res[k]);
        end else begin
          e = exp_q[k].pop_front();
          check($sformatf("res[%0d]", k), 32'(res[k]), 32'(e.res));
          check($sformatf("latency[%0d]", k), 32'(cyc - start_edge), 32'(e.lat));
        end
      end
    end
    rd_prev = rd;
  end

  task automatic push(input vec_t v, input logic [2:0] mask);
    int   m = (v.s0 + v.d0 > v.s1 + v.d1) ? v.s0 + v.d0 : v.s1 + v.d1;
    exp_t e;
    if (mask[0]) begin e.res = v.e_add;   e.lat = m + 3;     exp_q[0].push_back(e); end
    if (mask[1]) begin e.res = v.e_monus; e.lat = m + 3;     exp_q[1].push_back(e); end
    if (mask[2]) begin e.res = v.e_mul;   e.lat = m + 2 + W; exp_q[2].push_back(e); end
  endtask

  // Called at a negedge: ST low for one edge, then high.
  task automatic launch();
    ST = 1'b0;
    @(negedge CLK);
    ST = 1'b1;
    start_edge = cyc + 1;
  endtask

  // Child: waits for CST, keeps a stale RD=1 for s cycles, drops RD for d cycles,
  // then presents its value and corrupts CRES shortly afterwards.
  task automatic child(input int idx, input int s, input int d, input logic [W-1:0] val);
    int n = 0;
    while (cst[0] !== 1'b1 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 10) begin
      checks++;
      errors++;
      $display("FAIL cst_timeout[%0d]: no CST pulse within 10 cycles", idx);
      return;
    end
    cres[idx] = 16'hDEAD;
    repeat (s) @(negedge CLK);
    crd[idx] = 1'b0;
    repeat (d) @(negedge CLK);
    cres[idx] = val;
    crd[idx]  = 1'b1;
    @(negedge CLK);
    cres[idx] = 16'hBEEF;
  endtask

  task automatic pulse_checks();
    @(negedge CLK);
    check("cst_pulse", 32'(cst), 32'(3'b111));
    check("rd_busy", 32'(rd), 32'(3'b000));
    @(negedge CLK);
    check("cst_width", 32'(cst), 32'(3'b000));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rd !== 3'b111 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: RD=%b after 100 cycles, required 111", rd);
    end
    @(negedge CLK);
  endtask

  task automatic run(input vec_t v);
    push(v, 3'b111);
    launch();
    fork
      child(0, v.s0, v.d0, v.a);
      child(1, v.s1, v.d1, v.b);
      pulse_checks();
    join
    wait_idle();
  endtask

  initial begin
    vec_t v1, v2, vr;
    int   s1;

    //          a         b         d0 d1 s0 s1  add       monus     mul
    vecs[0] = '{16'h0003, 16'h0004, 2, 5, 0, 0, 16'h0007, 16'h0000, 16'h000C};
    vecs[1] = '{16'hFFFF, 16'h0002, 3, 2, 0, 0, 16'h0001, 16'hFFFD, 16'hFFFE};
    vecs[2] = '{16'h0005, 16'h0009, 4, 2, 0, 0, 16'h000E, 16'h0000, 16'h002D};
    vecs[3] = '{16'h0009, 16'h0005, 3, 3, 0, 0, 16'h000E, 16'h0004, 16'h002D};
    vecs[4] = '{16'h0102, 16'h0003, 2, 4, 0, 0, 16'h0105, 16'h00FF, 16'h0306};
    vecs[5] = '{16'h8000, 16'h0002, 5, 2, 0, 0, 16'h8002, 16'h7FFE, 16'h0000};
    vecs[6] = '{16'h1234, 16'h0011, 2, 3, 2, 2, 16'h1245, 16'h1223, 16'h3574};
    v1      = '{16'h0007, 16'h0006, 2, 3, 0, 0, 16'h000D, 16'h0001, 16'h002A};
    v2      = '{16'h0010, 16'h0010, 2, 2, 0, 0, 16'h0020, 16'h0000, 16'h0100};
    vr      = '{16'h0001, 16'h0001, 6, 6, 0, 0, 16'h0002, 16'h0000, 16'h0001};

    RST     = 1'b1;
    ST      = 1'b1;
    crd[0]  = 1'b1;
    crd[1]  = 1'b1;
    cres[0] = '0;
    cres[1] = '0;

    repeat (3) @(negedge CLK);
    check("reset_rd", 32'(rd), 32'(3'b111));
    check("reset_cst", 32'(cst), 32'(3'b000));
    for (int k = 0; k < 3; k++) check($sformatf("reset_res[%0d]", k), 32'(res[k]), 32'(0));
    RST = 1'b0;

    // ST stays high across reset release: no launch may follow.
    repeat (4) begin
      @(negedge CLK);
      check("held_st_cst", 32'(cst), 32'(3'b000));
      check("held_st_rd", 32'(rd), 32'(3'b111));
    end

    for (int i = 0; i < 7; i++) run(vecs[i]);

    // Restart while the MUL node is in iteration 7: MUL reports only the second op.
    push(v1, 3'b011);
    launch();
    s1 = start_edge;
    fork
      child(0, v1.s0, v1.d0, v1.a);
      child(1, v1.s1, v1.d1, v1.b);
      pulse_checks();
    join
    while (cyc < s1 + 10) @(negedge CLK);
    check("mul_busy_before_restart", 32'(rd[2]), 32'(0));
    push(v2, 3'b111);
    launch();
    fork
      child(0, v2.s0, v2.d0, v2.a);
      child(1, v2.s1, v2.d1, v2.b);
      pulse_checks();
    join
    wait_idle();

    // Reset while waiting on the children: no result, everything back to idle.
    launch();
    fork
      child(0, vr.s0, vr.d0, vr.a);
      child(1, vr.s1, vr.d1, vr.b);
      begin
        pulse_checks();
        RST = 1'b1;
        @(negedge CLK);
        check("midwait_reset_rd", 32'(rd), 32'(3'b111));
        check("midwait_reset_cst", 32'(cst), 32'(3'b000));
        for (int k = 0; k < 3; k++) check($sformatf("midwait_reset_res[%0d]", k), 32'(res[k]), 32'(0));
        @(negedge CLK);
        RST = 1'b0;
      end
    join
    wait_idle();

    // Recovery after the reset.
    run('{16'h0002, 16'h0003, 2, 2, 0, 0, 16'h0005, 16'h0000, 16'h0006});

    repeat (3) @(negedge CLK);
    for (int k = 0; k < 3; k++) check($sformatf("pending_results[%0d]", k), 32'(exp_q[k].size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
